// File: rtl/punc_pkg.sv
// Shared PUnC definitions: arbiter state encoding, port identifiers and bus widths.
package punc_pkg;
  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 16;
  localparam int HOST_WAIT_DEF = 4;

  typedef enum logic {
    ARB_S  = 1'b0,
    LOCK_S = 1'b1
  } arb_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_H = 1'b1;
endpackage

// File: rtl/punc_arb_starve_ctr.sv
// Host anti-starvation counter: counts consecutive denied host cycles and
// raises host_pri once the host has waited HOST_WAIT cycles.
module punc_arb_starve_ctr
  import punc_pkg::*;
#(
  parameter int HOST_WAIT = HOST_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic h_req,
  input  logic h_gnt,
  output logic host_pri
);
  localparam int CW = $clog2(HOST_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(HOST_WAIT);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!h_req || h_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign host_pri = h_req && (wait_cnt == WAIT_MAX);
endmodule

// File: rtl/punc_mem_arbiter.sv
// Single-port memory arbiter between the PUnC CPU and the host loader/debug port:
// fixed CPU priority, host anti-starvation, and a host lock for atomic bursts.
module punc_mem_arbiter
  import punc_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int HOST_WAIT = HOST_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          locked
);
  // Handshake: a requester holds req/we/addr/wdata stable until its gnt; a gnt
  // issues the access that same cycle, and read data returns exactly one cycle
  // later with rvalid, to the port that was granted.
  arb_state_t    state;
  logic          host_pri;
  logic          rd_pending;
  logic          rd_owner;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] h_rdata_q;

  punc_arb_starve_ctr #(.HOST_WAIT(HOST_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .h_req    (h_req),
    .h_gnt    (h_gnt),
    .host_pri (host_pri)
  );

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (!rst) begin
      if (state == LOCK_S) begin
        h_gnt = h_req;
      end else begin
        c_gnt = c_req && !host_pri;
        h_gnt = h_req && !c_gnt;
      end
    end
  end

  always_comb begin
    m_en    = c_gnt || h_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (h_gnt) begin
      m_we    = h_we;
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_S;
    end else begin
      case (state)
        ARB_S:   if (h_gnt && h_lock) state <= LOCK_S;
        LOCK_S:  if (!h_lock) state <= ARB_S;
        default: state <= ARB_S;
      endcase
    end
  end

  assign locked = (state == LOCK_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_owner   <= PORT_C;
    end else begin
      rd_pending <= m_en && !m_we;
      rd_owner   <= h_gnt ? PORT_H : PORT_C;
    end
  end

  assign c_rvalid = !rst && rd_pending && (rd_owner == PORT_C);
  assign h_rvalid = !rst && rd_pending && (rd_owner == PORT_H);

  // Read data passes straight through when valid and is held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= m_rdata;
      if (h_rvalid) h_rdata_q <= m_rdata;
    end
  end

  assign c_rdata = c_rvalid ? m_rdata : c_rdata_q;
  assign h_rdata = h_rvalid ? m_rdata : h_rdata_q;
endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed and random stimulus for punc_mem_arbiter, checked cycle by cycle
// against a transaction-level model of the arbitration rules and memory.
module tb_punc_mem_arbiter;
  localparam int HOST_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, h_req, h_we, h_lock;
  logic [15:0] c_addr, c_wdata, h_addr, h_wdata;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, m_en, m_we, locked;
  logic [15:0] c_rdata, h_rdata, m_addr, m_wdata, m_rdata;

  punc_mem_arbiter #(.AW(16), .DW(16), .HOST_WAIT(HOST_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .locked(locked)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Memory macro: synchronous read, one cycle latency.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:65535];
  int          denied;
  bit          mdl_lock;
  bit          exp_cv, exp_hv;
  logic [15:0] exp_cd, exp_hd;
  bit          g_c, g_h;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit       e_c, e_h, e_we;
    logic [15:0] e_addr, e_wdata;
    if (rst) begin
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_h_gnt", h_gnt, 0);
      chk("rst_m_en", m_en, 0);
      chk("rst_c_rvalid", c_rvalid, 0);
      chk("rst_h_rvalid", h_rvalid, 0);
      denied = 0; mdl_lock = 0;
      exp_cv = 0; exp_hv = 0; exp_cd = '0; exp_hd = '0;
      g_c = 0; g_h = 0;
      return;
    end
    if (mdl_lock) begin
      e_h = h_req; e_c = 0;
    end else begin
      e_c = c_req && !(h_req && denied >= HOST_WAIT);
      e_h = h_req && !e_c;
    end
    e_we    = e_c ? c_we    : (e_h ? h_we    : 1'b0);
    e_addr  = e_c ? c_addr  : (e_h ? h_addr  : 16'h0);
    e_wdata = e_c ? c_wdata : (e_h ? h_wdata : 16'h0);
    chk("c_gnt", c_gnt, e_c);
    chk("h_gnt", h_gnt, e_h);
    chk("m_en", m_en, e_c | e_h);
    chk("m_we", m_we, e_we);
    chk("m_addr", m_addr, e_addr);
    chk("m_wdata", m_wdata, e_wdata);
    chk("locked", locked, mdl_lock);
    chk("c_rvalid", c_rvalid, exp_cv);
    chk("c_rdata", c_rdata, exp_cd);
    chk("h_rvalid", h_rvalid, exp_hv);
    chk("h_rdata", h_rdata, exp_hd);
    // Advance the model to the next cycle.
    exp_cv = e_c && !c_we;
    exp_hv = e_h && !h_we;
    if (exp_cv) exp_cd = ref_mem[c_addr];
    if (exp_hv) exp_hd = ref_mem[h_addr];
    if (e_c && c_we) ref_mem[c_addr] = c_wdata;
    if (e_h && h_we) ref_mem[h_addr] = h_wdata;
    denied = (h_req && !e_h) ? ((denied < HOST_WAIT) ? denied + 1 : HOST_WAIT) : 0;
    if (mdl_lock) mdl_lock = h_lock;
    else          mdl_lock = e_h && h_lock;
    g_c = e_c; g_h = e_h;
  endtask

  // Driver: apply one cycle of inputs, check at negedge, return just after posedge.
  task automatic cyc(input bit r, input bit cr, input bit cw, input logic [15:0] ca,
                     input logic [15:0] cd, input bit hr, input bit hw, input bit hl,
                     input logic [15:0] ha, input logic [15:0] hd);
    rst = r;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    h_req = hr; h_we = hw; h_lock = hl; h_addr = ha; h_wdata = hd;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    int          cnt;
    bit          cr, cw, hr, hw, hl;
    logic [15:0] ca, cd, ha, hd;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5C3;
      ref_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    m_rdata = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    idle();

    // CPU-only back-to-back reads 0x0000..0x0003.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 16'(i), 16'h0, 0, 0, 0, 16'h0, 16'h0);
    idle();
    idle();

    // Both requesting continuously: 4 CPU grants then 1 host grant, repeating.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 16'h0100, 16'h0, 1, 0, 0, 16'h0200, 16'h0);
      if (g_h) cnt++;
    end
    chk("starve_h_gnt_count", cnt, 2);
    idle();
    idle();

    // Host read then CPU read on the next cycle: each gets its own data.
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h3000, 16'h0);
    cyc(0, 1, 0, 16'h0005, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    idle();
    idle();

    // Locked host burst of 8 writes while the CPU keeps requesting.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, i > 0, 0, 16'h0040, 16'h0, 1, 1, 1, 16'h3000 + 16'(i), 16'hB000 + 16'(i));
      if (g_h) cnt++;
    end
    chk("lock_h_gnt_count", cnt, 8);
    cyc(0, 1, 0, 16'h0040, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    cyc(0, 1, 0, 16'h0040, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    chk("unlock_c_gnt", g_c, 1);
    idle();
    // Host reads back part of the locked burst.
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h3003, 16'h0);
    idle();
    chk("burst_readback", h_rdata, 16'hB003);

    // CPU store then load of the same word.
    cyc(0, 1, 1, 16'h0010, 16'h1234, 0, 0, 0, 16'h0, 16'h0);
    cyc(0, 1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    idle();
    chk("store_load", c_rdata, 16'h1234);
    idle();

    // Reset in the cycle after a locked host read grant.
    cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h3001, 16'h0);
    cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    idle();
    chk("post_rst_h_rvalid", h_rvalid, 0);
    chk("post_rst_locked", locked, 0);
    chk("post_rst_h_rdata", h_rdata, 16'h0);

    // Random traffic; requesters hold their fields until granted.
    cr = 0; hr = 0; hl = 0; cw = 0; hw = 0;
    ca = '0; cd = '0; ha = '0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cr || g_c) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1);
        ca = 16'($urandom_range(0, 31));
        cd = 16'($urandom);
      end
      if (!hr || g_h) begin
        hr = ($urandom_range(0, 2) == 0);
        hw = $urandom_range(0, 1);
        ha = 16'($urandom_range(0, 31));
        hd = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) hl = !hl;
      cyc(0, cr, cw, ca, cd, hr, hw, hl, ha, hd);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
